winner_sequencer: RTL and testbench

Controller that sequences one routing decision through the winnerPolicy datapath. On start it latches the policy config and scans the neighbor Q-table in the shared byte-wide memory for the minimum-cost neighbor. It then drives winnerPolicy's operands, fires its done_prev, waits for done, and returns the chosen nexthop to the packet handler. A timeout protects against a hung policy block.

---
 rtl/winner_sequencer_pkg.sv | 29 ++
 rtl/winner_sequencer_nbr_table_scanner.sv | 113 +++++++++++
 rtl/winner_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_winner_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/winner_sequencer_pkg.sv
// Shared types and constants for the winner_sequencer controller and its
// neighbor-table scanner.
package winner_sequencer_pkg;

    localparam int WORD_WIDTH = 16;
    localparam logic [WORD_WIDTH-1:0] INF_VALUE = 16'hFFFF;

    // Byte offsets inside one 4-byte neighbor table entry (big-endian fields).
    localparam logic [1:0] OFS_ID_HI  = 2'd0;
    localparam logic [1:0] OFS_ID_LO  = 2'd1;
    localparam logic [1:0] OFS_VAL_HI = 2'd2;
    localparam logic [1:0] OFS_VAL_LO = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Number of bytes to read for a requested neighbor count, clamped to max_nbr.
    function automatic logic [9:0] scan_bytes(input logic [7:0] cnt, input logic [7:0] max_nbr);
        logic [7:0] n;
        n = (cnt > max_nbr) ? max_nbr : cnt;
        return {n, 2'b00};
    endfunction

endpackage

// File: rtl/winner_sequencer_nbr_table_scanner.sv
// Streams the neighbor table out of byte memory, reassembles entries and
// tracks the minimum-cost neighbor that is not this node.
module nbr_table_scanner
    import winner_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'd0,
    parameter int                MAX_NBR   = 64
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  i_start,
    input  logic [7:0]            i_count,
    input  logic [WORD_WIDTH-1:0] i_node_id,
    output logic                  o_mem_rd_en,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [7:0]            i_mem_data,
    output logic [WORD_WIDTH-1:0] o_best_id,
    output logic [WORD_WIDTH-1:0] o_best_value,
    output logic                  o_found,
    output logic                  o_scan_done
);

    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_addr;
    logic [9:0]            r_k;
    logic [9:0]            r_total;
    logic                  r_cap_valid;
    logic [1:0]            r_cap_idx;
    logic                  r_cap_last;
    logic [WORD_WIDTH-1:0] r_cand_id;
    logic [7:0]            r_val_hi;
    logic [WORD_WIDTH-1:0] r_best_id;
    logic [WORD_WIDTH-1:0] r_best_value;
    logic                  r_found;

    logic [WORD_WIDTH-1:0] w_cand_value;
    logic                  w_last_byte;
    logic                  w_upd;

    // The final byte is folded in combinationally so the result is usable on scan_done.
    assign w_cand_value = {r_val_hi, i_mem_data};
    assign w_last_byte  = r_cap_valid && (r_cap_idx == OFS_VAL_LO);
    assign w_upd        = w_last_byte && (r_cand_id != i_node_id) && (w_cand_value < r_best_value);

    assign o_mem_rd_en  = r_rd_en;
    assign o_mem_addr   = r_addr;
    assign o_best_id    = w_upd ? r_cand_id : r_best_id;
    assign o_best_value = w_upd ? w_cand_value : r_best_value;
    assign o_found      = r_found | w_upd;
    assign o_scan_done  = w_last_byte && r_cap_last;

    // Read address generator, one byte per cycle, wrapping at the memory size.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_k     <= 10'd0;
            r_total <= 10'd0;
        end else if (i_start) begin
            r_rd_en <= 1'b1;
            r_addr  <= BASE_ADDR;
            r_k     <= 10'd0;
            r_total <= scan_bytes(i_count, 8'(MAX_NBR));
        end else if (r_rd_en) begin
            if (r_k == r_total - 10'd1) begin
                r_rd_en <= 1'b0;
            end else begin
                r_k    <= r_k + 10'd1;
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Byte capture, entry assembly and strict-less-than minimum tracking.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_cap_valid  <= 1'b0;
            r_cap_idx    <= 2'd0;
            r_cap_last   <= 1'b0;
            r_cand_id    <= '0;
            r_val_hi     <= 8'd0;
            r_best_id    <= '0;
            r_best_value <= INF_VALUE;
            r_found      <= 1'b0;
        end else if (i_start) begin
            r_cap_valid  <= 1'b0;
            r_best_id    <= '0;
            r_best_value <= INF_VALUE;
            r_found      <= 1'b0;
        end else begin
            r_cap_valid <= r_rd_en;
            r_cap_idx   <= r_k[1:0];
            r_cap_last  <= (r_k == r_total - 10'd1);
            if (r_cap_valid) begin
                case (r_cap_idx)
                    OFS_ID_HI:  r_cand_id[15:8] <= i_mem_data;
                    OFS_ID_LO:  r_cand_id[7:0]  <= i_mem_data;
                    OFS_VAL_HI: r_val_hi        <= i_mem_data;
                    OFS_VAL_LO: begin
                        if (w_upd) begin
                            r_best_id    <= r_cand_id;
                            r_best_value <= w_cand_value;
                            r_found      <= 1'b1;
                        end
                    end
                    default: r_val_hi <= r_val_hi;
                endcase
            end
        end
    end

endmodule

// File: rtl/winner_sequencer.sv
// Sequences one routing decision: scan the neighbor table, launch winnerPolicy
// on the best neighbor, and return its nexthop (or a fallback on timeout).
module winner_sequencer
    import winner_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 10'd0,
    parameter int                TIMEOUT   = 255,
    parameter int                MAX_NBR   = 64
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [7:0]            neighbor_count,
    input  logic [WORD_WIDTH-1:0] epsilon,
    input  logic [WORD_WIDTH-1:0] my_best,
    input  logic [WORD_WIDTH-1:0] my_besthop,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [7:0]            mem_data,
    output logic [WORD_WIDTH-1:0] wp_epsilon,
    output logic [WORD_WIDTH-1:0] wp_mybest,
    output logic [WORD_WIDTH-1:0] wp_besthop,
    output logic [WORD_WIDTH-1:0] wp_bestvalue,
    output logic [WORD_WIDTH-1:0] wp_bestneighborID,
    output logic [WORD_WIDTH-1:0] wp_node_id,
    output logic                  wp_done_prev,
    input  logic                  wp_done,
    input  logic [WORD_WIDTH-1:0] wp_nexthop,
    output logic                  busy,
    output logic                  result_valid,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  err_timeout,
    output logic                  no_neighbor
);

    localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e                r_state;
    logic                  r_busy;
    logic                  r_result_valid;
    logic [WORD_WIDTH-1:0] r_nexthop;
    logic                  r_err_timeout;
    logic                  r_no_neighbor;
    logic                  r_found;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [WORD_WIDTH-1:0] r_epsilon;
    logic [WORD_WIDTH-1:0] r_my_best;
    logic [WORD_WIDTH-1:0] r_my_besthop;
    logic [WORD_WIDTH-1:0] r_node_id;
    logic [WORD_WIDTH-1:0] r_wp_epsilon;
    logic [WORD_WIDTH-1:0] r_wp_mybest;
    logic [WORD_WIDTH-1:0] r_wp_besthop;
    logic [WORD_WIDTH-1:0] r_wp_bestvalue;
    logic [WORD_WIDTH-1:0] r_wp_bestneighbor_id;
    logic [WORD_WIDTH-1:0] r_wp_node_id;
    logic                  r_wp_done_prev;

    logic                  w_scan_start;
    logic [WORD_WIDTH-1:0] w_best_id;
    logic [WORD_WIDTH-1:0] w_best_value;
    logic                  w_found;
    logic                  w_scan_done;

    assign w_scan_start = (r_state == ST_IDLE) && start && (neighbor_count != 8'd0);

    nbr_table_scanner #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .MAX_NBR   (MAX_NBR)
    ) u_scanner (
        .clock        (clock),
        .nreset       (nreset),
        .i_start      (w_scan_start),
        .i_count      (neighbor_count),
        .i_node_id    (r_node_id),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_addr   (mem_addr),
        .i_mem_data   (mem_data),
        .o_best_id    (w_best_id),
        .o_best_value (w_best_value),
        .o_found      (w_found),
        .o_scan_done  (w_scan_done)
    );

    assign busy              = r_busy;
    assign result_valid      = r_result_valid;
    assign nexthop           = r_nexthop;
    assign err_timeout       = r_err_timeout;
    assign no_neighbor       = r_no_neighbor;
    assign wp_epsilon        = r_wp_epsilon;
    assign wp_mybest         = r_wp_mybest;
    assign wp_besthop        = r_wp_besthop;
    assign wp_bestvalue      = r_wp_bestvalue;
    assign wp_bestneighborID = r_wp_bestneighbor_id;
    assign wp_node_id        = r_wp_node_id;
    assign wp_done_prev      = r_wp_done_prev;

    // Round sequencing FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state              <= ST_IDLE;
            r_busy               <= 1'b0;
            r_result_valid       <= 1'b0;
            r_nexthop            <= '0;
            r_err_timeout        <= 1'b0;
            r_no_neighbor        <= 1'b0;
            r_found              <= 1'b0;
            r_wait_cnt           <= '0;
            r_epsilon            <= '0;
            r_my_best            <= '0;
            r_my_besthop         <= '0;
            r_node_id            <= '0;
            r_wp_epsilon         <= '0;
            r_wp_mybest          <= '0;
            r_wp_besthop         <= '0;
            r_wp_bestvalue       <= INF_VALUE;
            r_wp_bestneighbor_id <= '0;
            r_wp_node_id         <= '0;
            r_wp_done_prev       <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_wp_done_prev <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy        <= 1'b1;
                        r_err_timeout <= 1'b0;
                        r_no_neighbor <= 1'b0;
                        r_epsilon     <= epsilon;
                        r_my_best     <= my_best;
                        r_my_besthop  <= my_besthop;
                        r_node_id     <= my_node_id;
                        if (neighbor_count == 8'd0) begin
                            r_state        <= ST_DONE;
                            r_no_neighbor  <= 1'b1;
                            r_nexthop      <= my_besthop;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (w_scan_done) begin
                        r_state <= ST_LAUNCH;
                        r_found <= w_found;
                        if (w_found) begin
                            r_wp_done_prev       <= 1'b1;
                            r_wp_epsilon         <= r_epsilon;
                            r_wp_mybest          <= r_my_best;
                            r_wp_besthop         <= r_my_besthop;
                            r_wp_bestvalue       <= w_best_value;
                            r_wp_bestneighbor_id <= w_best_id;
                            r_wp_node_id         <= r_node_id;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (r_found) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state        <= ST_DONE;
                        r_no_neighbor  <= 1'b1;
                        r_nexthop      <= r_my_besthop;
                        r_result_valid <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A completion on the final wait cycle beats the timeout.
                    if (wp_done) begin
                        r_state        <= ST_DONE;
                        r_nexthop      <= wp_nexthop;
                        r_result_valid <= 1'b1;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_state        <= ST_DONE;
                        r_err_timeout  <= 1'b1;
                        r_nexthop      <= r_my_besthop;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winner_sequencer.sv
// Directed self-checking bench for winner_sequencer: latency, tie/skip rules,
// clamping, timeout, address wrap and mid-round reset.
module tb_winner_sequencer;

    logic        clock;
    logic        nreset;
    logic        start;
    logic        start_w;
    logic [7:0]  neighbor_count;
    logic [15:0] epsilon, my_best, my_besthop, my_node_id;
    logic        wp_done;
    logic [15:0] wp_nexthop;

    logic        mem_rd_en, mem_rd_en_w;
    logic [9:0]  mem_addr, mem_addr_w;
    logic [7:0]  mem_data, mem_data_w;
    logic [15:0] wp_epsilon, wp_mybest, wp_besthop, wp_bestvalue, wp_bestneighborID, wp_node_id;
    logic [15:0] wp_epsilon_w, wp_mybest_w, wp_besthop_w, wp_bestvalue_w, wp_bestneighborID_w, wp_node_id_w;
    logic        wp_done_prev, wp_done_prev_w;
    logic        busy, busy_w, result_valid, result_valid_w;
    logic [15:0] nexthop, nexthop_w;
    logic        err_timeout, err_timeout_w, no_neighbor, no_neighbor_w;

    logic [7:0]  mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    int          rv_cyc, launch_cyc, dp_cnt, rd_cnt;
    logic        err_c1, busy_c1, busy_after, rv_after;
    logic [15:0] snap_id, snap_val;

    winner_sequencer dut (
        .clock(clock), .nreset(nreset), .start(start), .neighbor_count(neighbor_count),
        .epsilon(epsilon), .my_best(my_best), .my_besthop(my_besthop), .my_node_id(my_node_id),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .wp_epsilon(wp_epsilon), .wp_mybest(wp_mybest), .wp_besthop(wp_besthop),
        .wp_bestvalue(wp_bestvalue), .wp_bestneighborID(wp_bestneighborID), .wp_node_id(wp_node_id),
        .wp_done_prev(wp_done_prev), .wp_done(wp_done), .wp_nexthop(wp_nexthop),
        .busy(busy), .result_valid(result_valid), .nexthop(nexthop),
        .err_timeout(err_timeout), .no_neighbor(no_neighbor)
    );

    winner_sequencer #(.BASE_ADDR(10'd1022)) dut_w (
        .clock(clock), .nreset(nreset), .start(start_w), .neighbor_count(neighbor_count),
        .epsilon(epsilon), .my_best(my_best), .my_besthop(my_besthop), .my_node_id(my_node_id),
        .mem_rd_en(mem_rd_en_w), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
        .wp_epsilon(wp_epsilon_w), .wp_mybest(wp_mybest_w), .wp_besthop(wp_besthop_w),
        .wp_bestvalue(wp_bestvalue_w), .wp_bestneighborID(wp_bestneighborID_w), .wp_node_id(wp_node_id_w),
        .wp_done_prev(wp_done_prev_w), .wp_done(wp_done), .wp_nexthop(wp_nexthop),
        .busy(busy_w), .result_valid(result_valid_w), .nexthop(nexthop_w),
        .err_timeout(err_timeout_w), .no_neighbor(no_neighbor_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memory with one-cycle read latency.
    always @(posedge clock) begin
        if (mem_rd_en)   mem_data   <= mem[mem_addr];
        if (mem_rd_en_w) mem_data_w <= mem[mem_addr_w];
    end

    task automatic load_entry(input int base, input int idx, input logic [15:0] id, input logic [15:0] val);
        mem[(base + 4*idx)     % 1024] = id[15:8];
        mem[(base + 4*idx + 1) % 1024] = id[7:0];
        mem[(base + 4*idx + 2) % 1024] = val[15:8];
        mem[(base + 4*idx + 3) % 1024] = val[7:0];
    endtask

    // Runs one round on dut; policy answers d cycles after launch (d<0: never).
    task automatic run_round(input logic [7:0] cnt, input int d, input logic [15:0] ret, input int pulse_at);
        int  c;
        bit  got;
        rv_cyc = -1; launch_cyc = -1; dp_cnt = 0; rd_cnt = 0; got = 0;
        neighbor_count = cnt;
        start = 1'b1;
        @(posedge clock);
        c = 0;
        while (!got && c < 2000) begin
            @(negedge clock);
            c++;
            start = (c == pulse_at);
            if (c == 1) begin
                err_c1  = err_timeout;
                busy_c1 = busy;
            end
            if (mem_rd_en) rd_cnt++;
            if (wp_done_prev) begin
                dp_cnt++;
                if (launch_cyc < 0) begin
                    launch_cyc = c;
                    snap_id    = wp_bestneighborID;
                    snap_val   = wp_bestvalue;
                end
            end
            if (result_valid) begin
                rv_cyc = c;
                got    = 1;
            end
            wp_done    = (d >= 0 && launch_cyc >= 0 && c == launch_cyc + d);
            wp_nexthop = ret;
        end
        wp_done = 1'b0;
        start   = 1'b0;
        @(negedge clock);
        busy_after = busy;
        rv_after   = result_valid;
    endtask

    task automatic test_reset();
        nreset = 1'b0; start = 1'b0; start_w = 1'b0; wp_done = 1'b0; wp_nexthop = 16'd0;
        neighbor_count = 8'd0; epsilon = 16'h0123; my_best = 16'h1111; my_besthop = 16'd3; my_node_id = 16'd6;
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || wp_done_prev !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl busy=%b rv=%b dp=%b rd=%b expected 0000", busy, result_valid, wp_done_prev, mem_rd_en); end
        n_checks++; if (wp_bestvalue !== 16'hFFFF || wp_bestneighborID !== 16'h0000 || nexthop !== 16'h0000 || mem_addr !== 10'd0) begin
            n_fail++; $display("FAIL reset_data bv=%h bid=%h nh=%h addr=%0d expected ffff 0000 0000 0", wp_bestvalue, wp_bestneighborID, nexthop, mem_addr); end
        n_checks++; if (err_timeout !== 1'b0 || no_neighbor !== 1'b0 || wp_epsilon !== 16'h0 || wp_node_id !== 16'h0) begin
            n_fail++; $display("FAIL reset_flags err=%b nonb=%b eps=%h nid=%h expected 0 0 0 0", err_timeout, no_neighbor, wp_epsilon, wp_node_id); end
        nreset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        load_entry(0, 0, 16'd7, 16'h3C00);
        load_entry(0, 1, 16'd9, 16'h3800);
        load_entry(0, 2, 16'd4, 16'h3A00);
        run_round(8'd3, 2, 16'd9, 5);
        n_checks++; if (rv_cyc !== 17) begin n_fail++; $display("FAIL basic_latency got=%0d exp=17", rv_cyc); end
        n_checks++; if (launch_cyc !== 14 || dp_cnt !== 1) begin n_fail++; $display("FAIL basic_launch cyc=%0d cnt=%0d exp 14 1", launch_cyc, dp_cnt); end
        n_checks++; if (snap_id !== 16'd9 || snap_val !== 16'h3800) begin n_fail++; $display("FAIL basic_best id=%h val=%h exp 0009 3800", snap_id, snap_val); end
        n_checks++; if (wp_epsilon !== 16'h0123 || wp_mybest !== 16'h1111 || wp_besthop !== 16'd3 || wp_node_id !== 16'd6) begin
            n_fail++; $display("FAIL basic_operands eps=%h mb=%h bh=%h nid=%h", wp_epsilon, wp_mybest, wp_besthop, wp_node_id); end
        n_checks++; if (nexthop !== 16'd9 || err_timeout !== 1'b0 || no_neighbor !== 1'b0) begin
            n_fail++; $display("FAIL basic_result nh=%h err=%b nonb=%b exp 0009 0 0", nexthop, err_timeout, no_neighbor); end
        n_checks++; if (busy_c1 !== 1'b1 || busy_after !== 1'b0 || rv_after !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy c1=%b after=%b rv_after=%b exp 1 0 0", busy_c1, busy_after, rv_after); end
        n_checks++; if (rd_cnt !== 12) begin n_fail++; $display("FAIL busy_start_ignored reads=%0d exp=12", rd_cnt); end
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_queued_start busy=%b exp=0", busy); end
    endtask

    task automatic test_tie();
        load_entry(0, 0, 16'd2, 16'h3000);
        load_entry(0, 1, 16'd5, 16'h3000);
        run_round(8'd2, 1, 16'd5, -1);
        n_checks++; if (snap_id !== 16'd2 || snap_val !== 16'h3000) begin n_fail++; $display("FAIL tie_best id=%h val=%h exp 0002 3000", snap_id, snap_val); end
        n_checks++; if (rv_cyc !== 12 || nexthop !== 16'd5) begin n_fail++; $display("FAIL tie_result cyc=%0d nh=%h exp 12 0005", rv_cyc, nexthop); end
    endtask

    task automatic test_skip_self();
        load_entry(0, 0, 16'd6, 16'h1000);
        load_entry(0, 1, 16'd8, 16'h2000);
        load_entry(0, 2, 16'd6, 16'h0100);
        run_round(8'd3, 3, 16'd8, -1);
        n_checks++; if (snap_id !== 16'd8 || snap_val !== 16'h2000 || rv_cyc !== 18) begin
            n_fail++; $display("FAIL skip_mixed id=%h val=%h cyc=%0d exp 0008 2000 18", snap_id, snap_val, rv_cyc); end
        load_entry(0, 0, 16'd6, 16'h1000);
        load_entry(0, 1, 16'd6, 16'h0100);
        run_round(8'd2, 1, 16'h00EE, -1);
        n_checks++; if (no_neighbor !== 1'b1 || nexthop !== 16'd3 || dp_cnt !== 0 || rv_cyc !== 11) begin
            n_fail++; $display("FAIL skip_all nonb=%b nh=%h dp=%0d cyc=%0d exp 1 0003 0 11", no_neighbor, nexthop, dp_cnt, rv_cyc); end
        my_besthop = 16'h0044;
        run_round(8'd0, 1, 16'h00EE, -1);
        n_checks++; if (no_neighbor !== 1'b1 || nexthop !== 16'h0044 || dp_cnt !== 0 || rv_cyc !== 1 || rd_cnt !== 0) begin
            n_fail++; $display("FAIL zero_count nonb=%b nh=%h dp=%0d cyc=%0d rd=%0d exp 1 0044 0 1 0", no_neighbor, nexthop, dp_cnt, rv_cyc, rd_cnt); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 63; i++) load_entry(0, i, 16'(100 + i), 16'h7000);
        load_entry(0, 63, 16'hABCD, 16'h0001);
        load_entry(0, 64, 16'h0077, 16'h0000);
        run_round(8'd200, 1, 16'hABCD, -1);
        n_checks++; if (rd_cnt !== 256 || rv_cyc !== 260) begin n_fail++; $display("FAIL clamp_len reads=%0d cyc=%0d exp 256 260", rd_cnt, rv_cyc); end
        n_checks++; if (snap_id !== 16'hABCD || snap_val !== 16'h0001) begin n_fail++; $display("FAIL clamp_best id=%h val=%h exp abcd 0001", snap_id, snap_val); end
    endtask

    task automatic test_timeout();
        my_besthop = 16'h0055;
        load_entry(0, 0, 16'd9, 16'h3800);
        run_round(8'd1, -1, 16'h0099, -1);
        n_checks++; if (err_timeout !== 1'b1 || nexthop !== 16'h0055 || rv_cyc !== 262) begin
            n_fail++; $display("FAIL timeout err=%b nh=%h cyc=%0d exp 1 0055 262", err_timeout, nexthop, rv_cyc); end
        run_round(8'd1, 255, 16'h0099, -1);
        n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL timeout_clear err_at_c1=%b exp=0", err_c1); end
        n_checks++; if (err_timeout !== 1'b0 || nexthop !== 16'h0099 || rv_cyc !== 262) begin
            n_fail++; $display("FAIL done_beats_timeout err=%b nh=%h cyc=%0d exp 0 0099 262", err_timeout, nexthop, rv_cyc); end
    endtask

    task automatic test_wrap();
        int   c, n_rd, launch, rv;
        bit   got;
        logic [9:0] addrs [4];
        mem[1022] = 8'h00; mem[1023] = 8'h21; mem[0] = 8'h12; mem[1] = 8'h34;
        for (int i = 0; i < 4; i++) addrs[i] = 10'd0;
        neighbor_count = 8'd1;
        start_w = 1'b1;
        @(posedge clock);
        c = 0; n_rd = 0; launch = -1; rv = -1; got = 0;
        while (!got && c < 100) begin
            @(negedge clock);
            c++;
            start_w = 1'b0;
            if (mem_rd_en_w) begin
                if (n_rd < 4) addrs[n_rd] = mem_addr_w;
                n_rd++;
            end
            if (wp_done_prev_w && launch < 0) launch = c;
            if (result_valid_w) begin got = 1; rv = c; end
            wp_done    = (launch >= 0 && c == launch + 1);
            wp_nexthop = 16'h0021;
        end
        wp_done = 1'b0;
        n_checks++; if (n_rd !== 4 || addrs[0] !== 10'd1022 || addrs[1] !== 10'd1023 || addrs[2] !== 10'd0 || addrs[3] !== 10'd1) begin
            n_fail++; $display("FAIL wrap_addr n=%0d a=%0d,%0d,%0d,%0d exp 4 1022,1023,0,1", n_rd, addrs[0], addrs[1], addrs[2], addrs[3]); end
        n_checks++; if (wp_bestneighborID_w !== 16'h0021 || wp_bestvalue_w !== 16'h1234 || nexthop_w !== 16'h0021 || rv !== 8) begin
            n_fail++; $display("FAIL wrap_result id=%h val=%h nh=%h cyc=%0d exp 0021 1234 0021 8", wp_bestneighborID_w, wp_bestvalue_w, nexthop_w, rv); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_scan();
        bit rv_seen;
        my_besthop = 16'd3;
        load_entry(0, 0, 16'd7, 16'h3C00);
        load_entry(0, 1, 16'd9, 16'h3800);
        load_entry(0, 2, 16'd4, 16'h3A00);
        neighbor_count = 8'd3;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        nreset = 1'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset busy=%b rv=%b rd=%b exp 0 0 0", busy, result_valid, mem_rd_en); end
        nreset = 1'b1;
        rv_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (result_valid) rv_seen = 1;
        end
        n_checks++; if (rv_seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_result rv_seen=%b exp=0", rv_seen); end
        run_round(8'd3, 2, 16'd9, -1);
        n_checks++; if (rv_cyc !== 17 || nexthop !== 16'd9 || snap_id !== 16'd9) begin
            n_fail++; $display("FAIL after_reset_round cyc=%0d nh=%h id=%h exp 17 0009 0009", rv_cyc, nexthop, snap_id); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        test_reset();
        test_basic();
        test_tie();
        test_skip_self();
        test_clamp();
        test_timeout();
        test_wrap();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
